uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage. Consumes the serial line driven by the team's UART transmitter.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB-first, optional even-parity bit, 1 stop bit (1). Idle line is 1.
- Samples the line on an oversampling tick from the shared baud generator. Delivers each byte with a one-clock valid pulse plus parity and framing status.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- OVERSAMPLE, 16, iTick pulses per bit period; even value, at least 8.
- PARITY_EN, 1, 1 = parity bit present and checked (even parity); 0 = no parity bit.

Ports:
- iClk  input  1  system clock; all state changes on its rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iTick  input  1  oversample strobe, one iClk wide, OVERSAMPLE per bit period.
- iRx  input  1  asynchronous serial line, idle high.
- oData  output  DATA_BITS  last received byte; held until the next frame completes.
- oValid  output  1  one-iClk pulse when oData and the status flags update.
- oParityErr  output  1  parity mismatch on the last frame; updated with oValid.
- oFrameErr  output  1  stop bit sampled 0 on the last frame; updated with oValid.
- oBusy  output  1  high from start-edge detection until return to IDLE.

Behaviour:
- Reset (iRst_n=0, asynchronous, any state, including mid-frame):
  - state=IDLE.
  - oData=0, oValid=0, oParityErr=0, oFrameErr=0, oBusy=0.
  - Synchronizer flops=1; tick counter=0; bit counter=0.
- Input synchronization: iRx passes through 2 flops (reset to 1). All decisions use the synchronized value rxs, which lags iRx by 2 iClk.
- Counters:
  - Tick counter width is clog2(OVERSAMPLE). It advances only on cycles with iTick=1.
  - Bit counter width is clog2(DATA_BITS).
- IDLE:
  - On rxs=0: go to START, clear the tick counter, set oBusy=1.
  - A falling edge is detected without iTick.
- START:
  - On the iTick that brings the tick count to OVERSAMPLE/2-1 (mid start bit), sample rxs.
  - rxs=1: false start; go to IDLE, oBusy=0, no oValid.
  - rxs=0: go to DATA, clear both counters.
- DATA:
  - Sample rxs every OVERSAMPLE ticks, at tick count OVERSAMPLE-1 (mid-bit).
  - Shift the sample into the MSB of the shift register (LSB-first reception) and accumulate XOR parity.
  - After DATA_BITS samples: go to PARITY if PARITY_EN=1, else STOP.
- PARITY:
  - Sample one bit after OVERSAMPLE ticks.
  - Parity error = (XOR of data bits) XOR (sampled bit).
- STOP:
  - Sample one bit after OVERSAMPLE ticks. On that sample, in the same iClk:
    - load oData from the shift register;
    - load oParityErr (forced to 0 when PARITY_EN=0);
    - load oFrameErr = ~rxs;
    - assert oValid on the following iClk for exactly one cycle.
  - If stop=1: go to IDLE, oBusy=0. oValid fires in the first IDLE cycle.
  - If stop=0: go to BREAK (oBusy stays 1).
- BREAK: wait until rxs=1, then go to IDLE, oBusy=0. No new start is detected while the line stays low.
- Latency: oValid rises 1 iClk after the mid-stop-bit sample, i.e. about 9.5 bit periods (10.5 with parity) plus 3 iClk after the iRx falling edge.
- Back-to-back frames:
  - A start edge arriving in the first IDLE cycle is accepted.
  - oValid of the previous frame is not lost or merged.
- iTick=0: all counters hold. The FSM stalls, except for IDLE edge detection and BREAK exit.
- oData, oParityErr and oFrameErr are stable between oValid pulses. Consumers must not rely on them before the first oValid after reset.
- Unused state encodings return to IDLE on the next iClk.

Test Plan:
- OVERSAMPLE=16, iTick every iClk, PARITY_EN=1; send 0xA5 with parity 0 and stop 1 -> one oValid pulse, oData=0xA5, oParityErr=0, oFrameErr=0, oBusy low the cycle after.
- Send 0x3C with parity bit 1 (wrong) -> oData=0x3C, oParityErr=1, oFrameErr=0. Then send 0x3C with parity 0 -> oParityErr clears to 0.
- Send 0x55 with stop bit 0, then hold iRx=0 for 40 bit periods, then release -> one oValid, oData=0x55, oFrameErr=1, oBusy=1 until the line is high. No further oValid during the hold.
- Pulse iRx low for 4 ticks (glitch) in IDLE -> no oValid, oBusy returns to 0 at the mid-start check, data outputs unchanged.
- Back-to-back 0x00 then 0xFF, second start bit immediately after the first stop bit; iTick every 3rd iClk -> exactly two oValid pulses, oData=0x00 then 0xFF, no errors.
- Assert iRst_n=0 for 2 iClk mid-DATA of 0x81, then send 0x7E cleanly -> outputs 0 during reset, no oValid for 0x81, next oValid shows oData=0x7E.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: serial-to-parallel UART receive stage.
// Frame: start bit (0), DATA_BITS data bits LSB-first, optional even-parity bit, stop bit (1).
// The line is sampled near mid-bit using the shared oversampling tick.
//
// Ports:
//   iClk        system clock, rising edge
//   iRst_n      asynchronous active-low reset
//   iTick       oversample strobe, OVERSAMPLE pulses per bit period
//   iRx         asynchronous serial line, idle high
//   oData       last received data word, held until the next frame completes
//   oValid      one-cycle pulse when oData and the status flags update
//   oParityErr  parity mismatch on the last frame
//   oFrameErr   stop bit sampled low on the last frame
//   oBusy       high from start-edge detection until return to idle
module uart_receiver #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned PARITY_EN  = 1
) (
   input  logic                 iClk,
   input  logic                 iRst_n,
   input  logic                 iTick,
   input  logic                 iRx,
   output logic [DATA_BITS-1:0] oData,
   output logic                 oValid,
   output logic                 oParityErr,
   output logic                 oFrameErr,
   output logic                 oBusy
);

   localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] TickLast = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TickHalf = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [BW-1:0] BitLast  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } state_e;

   state_e                 state_q;
   logic                   rx_meta_q;
   logic                   rxs_q;
   logic [TW-1:0]          tick_cnt_q;
   logic [BW-1:0]          bit_cnt_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   par_acc_q;
   logic                   par_err_q;
   logic [DATA_BITS-1:0]   data_q;
   logic                   valid_q;
   logic                   parity_err_q;
   logic                   frame_err_q;
   logic                   busy_q;

   // Sample point inside the current bit: half a bit for the start bit, full bit otherwise.
   logic sample_mid;
   logic sample_full;
   assign sample_mid  = iTick && (tick_cnt_q == TickHalf);
   assign sample_full = iTick && (tick_cnt_q == TickLast);

   // Two-flop synchronizer; resets to the idle line level so reset never looks like a start.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= iRx;
         rxs_q     <= rx_meta_q;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q      <= StIdle;
         tick_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_acc_q    <= 1'b0;
         par_err_q    <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               // Edge detection runs every cycle, independent of iTick.
               if (!rxs_q) begin
                  state_q    <= StStart;
                  tick_cnt_q <= '0;
                  busy_q     <= 1'b1;
               end
            end
            StStart: begin
               if (sample_mid) begin
                  if (rxs_q) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q    <= StData;
                     tick_cnt_q <= '0;
                     bit_cnt_q  <= '0;
                     par_acc_q  <= 1'b0;
                  end
               end else if (iTick) begin
                  tick_cnt_q <= tick_cnt_q + TW'(1);
               end
            end
            StData: begin
               if (sample_full) begin
                  tick_cnt_q <= '0;
                  shift_q    <= {rxs_q, shift_q[DATA_BITS-1:1]};
                  par_acc_q  <= par_acc_q ^ rxs_q;
                  if (bit_cnt_q == BitLast) begin
                     bit_cnt_q <= '0;
                     state_q   <= (PARITY_EN != 0) ? StParity : StStop;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BW'(1);
                  end
               end else if (iTick) begin
                  tick_cnt_q <= tick_cnt_q + TW'(1);
               end
            end
            StParity: begin
               if (sample_full) begin
                  tick_cnt_q <= '0;
                  par_err_q  <= par_acc_q ^ rxs_q;
                  state_q    <= StStop;
               end else if (iTick) begin
                  tick_cnt_q <= tick_cnt_q + TW'(1);
               end
            end
            StStop: begin
               if (sample_full) begin
                  tick_cnt_q   <= '0;
                  data_q       <= shift_q;
                  parity_err_q <= (PARITY_EN != 0) ? par_err_q : 1'b0;
                  frame_err_q  <= ~rxs_q;
                  valid_q      <= 1'b1;
                  if (rxs_q) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end else begin
                     // Line held low: wait for it to recover before hunting a new start.
                     state_q <= StBreak;
                  end
               end else if (iTick) begin
                  tick_cnt_q <= tick_cnt_q + TW'(1);
               end
            end
            StBreak: begin
               if (rxs_q) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign oData      = data_q;
   assign oValid     = valid_q;
   assign oParityErr = parity_err_q;
   assign oFrameErr  = frame_err_q;
   assign oBusy      = busy_q;

endmodule
